// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
package bp_pkg;

    localparam int BP_ENTRIES_DEFAULT = 16;

    // 2-bit saturating direction counter; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    // One training step: count up on taken, down on not-taken, saturating both ways.
    function automatic bp_ctr_t bp_ctr_next(bp_ctr_t cur, logic taken);
        bp_ctr_t nxt;
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next-state for a 2-bit saturating counter, with a force-to-ST override.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] i_cur,
    input  logic       i_taken,
    input  logic       i_force_st,
    output logic [1:0] o_nxt
);

    // Unconditional transfers pin the counter at strongly-taken.
    always_comb begin
        o_nxt = i_cur;
        if (i_force_st) begin
            o_nxt = ST;
        end else begin
            o_nxt = bp_ctr_next(bp_ctr_t'(i_cur), i_taken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency IF lookup, EX-stage
// mispredict detection/redirect, table training on the clock edge, and
// saturating performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEFAULT,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] f_pc,
    output logic        f_pred_taken,
    output logic [31:0] f_pred_target,
    input  logic        r_valid,
    input  logic        r_is_jump,
    input  logic [31:0] r_pc,
    input  logic        r_taken,
    input  logic [31:0] r_target,
    input  logic        r_pred_taken,
    input  logic [31:0] r_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] cnt_branches,
    output logic [31:0] cnt_mispred
);

    logic             r_tbl_vld [ENTRIES];
    logic [TAG_W-1:0] r_tbl_tag [ENTRIES];
    logic [31:0]      r_tbl_tgt [ENTRIES];
    bp_ctr_t          r_tbl_ctr [ENTRIES];
    logic [31:0]      r_cnt_br;
    logic [31:0]      r_cnt_mp;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic [31:0]      w_f_seq;
    logic [IDX_W-1:0] w_r_idx;
    logic [TAG_W-1:0] w_r_tag;
    logic             w_r_hit;
    logic [31:0]      w_r_seq;
    logic             w_act_taken;
    logic [31:0]      w_act_next;
    logic             w_mispredict;
    logic [1:0]       w_ctr_upd;
    bp_ctr_t          w_ctr_new;
    logic             w_unused_pc_bits;

    // Instruction PCs are word aligned; the low two bits carry no information.
    assign w_unused_pc_bits = &{1'b0, f_pc[1:0], r_pc[1:0]};

    assign w_f_idx = f_pc[IDX_W+1:2];
    assign w_f_tag = f_pc[31:IDX_W+2];
    assign w_f_seq = f_pc + 32'd4;
    assign w_r_idx = r_pc[IDX_W+1:2];
    assign w_r_tag = r_pc[31:IDX_W+2];
    assign w_r_seq = r_pc + 32'd4;

    // IF lookup reads the tables as they stand before any same-cycle update.
    always_comb begin
        w_f_hit       = r_tbl_vld[w_f_idx] && (r_tbl_tag[w_f_idx] == w_f_tag);
        f_pred_taken  = rst_n && w_f_hit && r_tbl_ctr[w_f_idx][1];
        f_pred_target = f_pred_taken ? r_tbl_tgt[w_f_idx] : w_f_seq;
    end

    // EX resolution: compare actual outcome against what IF predicted.
    always_comb begin
        w_act_taken  = r_is_jump | r_taken;
        w_act_next   = w_act_taken ? r_target : w_r_seq;
        w_mispredict = rst_n && r_valid &&
                       ((w_act_taken != r_pred_taken) ||
                        (w_act_taken && (r_target != r_pred_target)));
        mispredict   = w_mispredict;
        redirect_pc  = rst_n ? w_act_next : w_r_seq;
    end

    bp_sat_counter u_sat (
        .i_cur      (r_tbl_ctr[w_r_idx]),
        .i_taken    (w_act_taken),
        .i_force_st (r_is_jump),
        .o_nxt      (w_ctr_upd)
    );

    // A tag hit trains the existing counter; a miss allocates with a fresh bias.
    always_comb begin
        w_r_hit   = r_tbl_vld[w_r_idx] && (r_tbl_tag[w_r_idx] == w_r_tag);
        w_ctr_new = WNT;
        if (w_r_hit) begin
            w_ctr_new = bp_ctr_t'(w_ctr_upd);
        end else if (r_is_jump) begin
            w_ctr_new = ST;
        end else if (w_act_taken) begin
            w_ctr_new = WT;
        end
    end

    // Valid bits and counters clear asynchronously; trained on every resolved transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tbl_vld[i] <= 1'b0;
                r_tbl_ctr[i] <= WNT;
            end
        end else if (r_valid) begin
            r_tbl_vld[w_r_idx] <= 1'b1;
            r_tbl_ctr[w_r_idx] <= w_ctr_new;
        end
    end

    // Tag and target need no reset: they are only consulted behind a valid bit.
    always_ff @(posedge clk) begin
        if (r_valid) begin
            r_tbl_tag[w_r_idx] <= w_r_tag;
            if (w_act_taken) begin
                r_tbl_tgt[w_r_idx] <= r_target;
            end
        end
    end

    // Saturating performance counters for resolved transfers and mispredicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_br <= '0;
            r_cnt_mp <= '0;
        end else begin
            if (r_valid && (r_cnt_br != 32'hFFFF_FFFF)) begin
                r_cnt_br <= r_cnt_br + 32'd1;
            end
            if (w_mispredict && (r_cnt_mp != 32'hFFFF_FFFF)) begin
                r_cnt_mp <= r_cnt_mp + 32'd1;
            end
        end
    end

    assign cnt_branches = r_cnt_br;
    assign cnt_mispred  = r_cnt_mp;

endmodule
